// File: rtl/serial2_parallel_rx.sv
// serial2_parallel_rx: SPI-side deserializer for the CPLD ADC sample stream.
// Oversamples sclk/spi_cs/mosi on clkin and rebuilds 12-bit LSB-first words.
// Each word is tagged with its channel index and buffered in a small FIFO.
// Frame length is checked, and a framing error is flagged on a bad frame.
module serial2_parallel_rx #(
  parameter  int ADC_CHIP_NO     = 4,
  parameter  int CH_PER_CHIP     = 4,
  parameter  int WORD_BITS       = 12,
  parameter  int FIFO_DEPTH      = 4,
  parameter  int SYNC_STAGES     = 2,
  localparam int WORDS_PER_FRAME = ADC_CHIP_NO * CH_PER_CHIP,
  localparam int CH_W            = $clog2(WORDS_PER_FRAME)
) (
  input  logic                 clkin,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 spi_cs,
  input  logic                 mosi,
  output logic [WORD_BITS-1:0] dout,
  output logic [CH_W-1:0]      dout_ch,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic                 overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BIT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam int WC_W  = $clog2(WORDS_PER_FRAME + 1);
  localparam int ENT_W = WORD_BITS + CH_W;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_CS
  } state_t;

  // Synchronizers and edge history
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   rise;
  logic                   cs_fall;
  logic                   cs_rise;

  // Deserializer state
  state_t                 state;
  logic [WORD_BITS-1:0]   sreg;
  logic [WORD_BITS-1:0]   sreg_next;
  logic [BIT_W-1:0]       bitcnt;
  logic [WC_W-1:0]        wordcnt;
  logic                   excess;
  logic                   push_req;

  // FIFO
  logic [ENT_W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         count;
  logic                   full;
  logic                   pop;
  logic                   push_ok;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_d;
  assign cs_fall = ~cs_s & cs_d;
  assign cs_rise = cs_s & ~cs_d;

  // Bring the asynchronous SPI pins into the clkin domain; sclk/cs idle high
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b1;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync[0] <= sclk;
      cs_sync[0]   <= spi_cs;
      mosi_sync[0] <= mosi;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        cs_sync[i]   <= cs_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
      end
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  // cs_rise takes priority over a coincident sclk rise, so it blocks the push
  assign sreg_next = {mosi_s, sreg[WORD_BITS-1:1]};
  assign push_req  = (state == SHIFT) && rise && !cs_rise &&
                     (bitcnt == BIT_W'(WORD_BITS - 1));

  // Frame FSM: shift bits, count words, pulse done/err at frame close
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      bitcnt     <= '0;
      wordcnt    <= '0;
      excess     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            sreg    <= '0;
            bitcnt  <= '0;
            wordcnt <= '0;
            excess  <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            if ((bitcnt != '0) || (wordcnt < WC_W'(WORDS_PER_FRAME))) begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end else if (rise) begin
            sreg <= sreg_next;
            if (bitcnt == BIT_W'(WORD_BITS - 1)) begin
              bitcnt  <= '0;
              wordcnt <= wordcnt + WC_W'(1);
              if (wordcnt == WC_W'(WORDS_PER_FRAME - 1)) begin
                state <= WAIT_CS;
              end
            end else begin
              bitcnt <= bitcnt + BIT_W'(1);
            end
          end
        end
        WAIT_CS: begin
          if (cs_rise) begin
            if (excess) begin
              frame_err <= 1'b1;
            end else begin
              frame_done <= 1'b1;
            end
            state <= IDLE;
          end else if (rise) begin
            excess <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pop is honoured first, so a push into a full FIFO succeeds when it pops
  assign dout_valid = (count != '0);
  assign full       = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign pop        = dout_valid && dout_ready;
  assign push_ok    = push_req && (!full || pop);
  assign dout       = mem[rd_ptr][ENT_W-1:CH_W];
  assign dout_ch    = mem[rd_ptr][CH_W-1:0];

  // Output FIFO storage, pointers and sticky overflow flag
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {sreg_next, wordcnt[CH_W-1:0]};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial2_parallel_rx.sv
// tb_serial2_parallel_rx: random and directed SPI frames against a queue model.
module tb_serial2_parallel_rx;

  localparam int WB    = 12;
  localparam int NW    = 16;
  localparam int DEPTH = 4;
  localparam int H     = 3;

  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b1;
  logic        spi_cs = 1'b1;
  logic        mosi = 1'b0;
  logic        dout_ready = 1'b0;
  logic [11:0] dout;
  logic [3:0]  dout_ch;
  logic        dout_valid;
  logic        frame_done;
  logic        frame_err;
  logic        overflow;

  int          total = 0;
  int          bad = 0;
  int          pops = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          ready_mode = 0;
  logic        model_ovf = 1'b0;
  logic        ovf_seen = 1'b0;
  logic [11:0] last_data = '0;
  logic [3:0]  last_ch = '0;
  logic [15:0] mq[$];
  logic [11:0] fw [0:16];

  always #5 clkin = ~clkin;

  serial2_parallel_rx #(
    .ADC_CHIP_NO (4),
    .CH_PER_CHIP (4),
    .WORD_BITS   (12),
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clkin      (clkin),
    .rst        (rst),
    .sclk       (sclk),
    .spi_cs     (spi_cs),
    .mosi       (mosi),
    .dout       (dout),
    .dout_ch    (dout_ch),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  // Compare process: every accepted head must match the model queue in order
  always @(negedge clkin) begin
    logic [15:0] e;
    if (!rst) begin
      if (frame_done) done_cnt++;
      if (frame_err) err_cnt++;
      if (ovf_seen) check("overflow_sticky", overflow, 1'b1);
      if (overflow) ovf_seen = 1'b1;
      if (dout_valid && dout_ready) begin
        if (mq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h ch %0d expected none", dout, dout_ch);
        end else begin
          e = mq.pop_front();
          check("dout", dout, e[15:4]);
          check("dout_ch", dout_ch, e[3:0]);
          pops++;
          last_data = dout;
          last_ch = dout_ch;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clkin);
      #1;
      dout_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end
  end

  // Send bits [0, nbits) of fw LSB first; model records each completed word
  task automatic send_bits(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = fw[i / WB][i % WB];
      wait_clk(H);
      sclk = 1'b1;
      if ((i % WB == WB - 1) && (i / WB < NW)) begin
        if (mq.size() >= DEPTH) model_ovf = 1'b1;
        else mq.push_back({fw[i / WB], 4'(i / WB)});
      end
      wait_clk(H);
    end
  endtask

  task automatic send_frame(input int nbits);
    spi_cs = 1'b0;
    wait_clk(4);
    send_bits(nbits);
    wait_clk(4);
    spi_cs = 1'b1;
    wait_clk(8);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((mq.size() != 0 || dout_valid) && n < 400) begin
      wait_clk(1);
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL %s_drain: got %0d pending expected 0", name, mq.size());
    end
  endtask

  task automatic run_frame(input string name, input int nbits);
    int d0, e0, p0, exp_words;
    d0 = done_cnt;
    e0 = err_cnt;
    p0 = pops;
    exp_words = (nbits / WB < NW) ? nbits / WB : NW;
    send_frame(nbits);
    check({name, "_done"}, done_cnt - d0, (nbits == NW * WB) ? 1 : 0);
    check({name, "_err"}, err_cnt - e0, (nbits != NW * WB) ? 1 : 0);
    drain(name);
    check({name, "_words"}, pops - p0, exp_words);
    check({name, "_ovf"}, overflow, model_ovf);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_dout"}, dout, 0);
    check({name, "_dout_ch"}, dout_ch, 0);
    check({name, "_valid"}, dout_valid, 0);
    check({name, "_done"}, frame_done, 0);
    check({name, "_err"}, frame_err, 0);
    check({name, "_ovf"}, overflow, 0);
  endtask

  initial begin
    int lsb_bits [12] = '{0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};
    int d0, p0, nb;

    #12;
    check_zero_outputs("reset");
    @(posedge clkin);
    #1;
    rst = 1'b0;
    wait_clk(5);
    ready_mode = 1;

    // Single frame of 0x000..0xFFF
    for (int k = 0; k < 17; k++) fw[k] = 12'(k * 12'h111);
    run_frame("single", NW * WB);
    check("single_last_data", last_data, 12'hFFF);
    check("single_last_ch", last_ch, 4'd15);

    // LSB-first pin: one word built from the bit sequence on the wire
    for (int i = 0; i < 12; i++) fw[0][i] = lsb_bits[i][0];
    run_frame("lsb", WB);
    check("lsb_data", last_data, 12'hA5C);
    check("lsb_ch", last_ch, 4'd0);

    // Short and long frames
    for (int k = 0; k < 17; k++) fw[k] = 12'($urandom);
    run_frame("short", 5 * WB + 7);
    for (int k = 0; k < 17; k++) fw[k] = 12'($urandom);
    run_frame("long", NW * WB + 3);

    // Random frames with random consumer stalls
    ready_mode = 2;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 17; k++) fw[k] = 12'($urandom);
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 200)) : NW * WB;
      run_frame("rand", nb);
    end

    // Backpressure: consumer stalled for a whole frame
    ready_mode = 0;
    wait_clk(4);
    for (int k = 0; k < 17; k++) fw[k] = 12'(k * 12'h111);
    d0 = done_cnt;
    p0 = pops;
    send_frame(NW * WB);
    check("bp_done", done_cnt - d0, 1);
    check("bp_ovf", overflow, 1'b1);
    check("bp_valid", dout_valid, 1'b1);
    check("bp_head", dout, 12'h000);
    ready_mode = 1;
    drain("bp");
    check("bp_words", pops - p0, 4);
    check("bp_last", last_data, 12'h333);
    for (int k = 0; k < 17; k++) fw[k] = 12'($urandom);
    run_frame("after_ovf", NW * WB);

    // Reset in the middle of word 2, with two words held in the FIFO
    ready_mode = 0;
    wait_clk(4);
    for (int k = 0; k < 17; k++) fw[k] = 12'($urandom);
    spi_cs = 1'b0;
    wait_clk(4);
    send_bits(2 * WB + 6);
    wait_clk(6);
    check("pre_rst_valid", dout_valid, 1'b1);
    @(posedge clkin);
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    mq.delete();
    model_ovf = 1'b0;
    ovf_seen = 1'b0;
    spi_cs = 1'b1;
    sclk = 1'b1;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(5);
    ready_mode = 1;
    for (int k = 0; k < 17; k++) fw[k] = 12'($urandom);
    p0 = pops;
    run_frame("post_rst", NW * WB);
    check("post_rst_last_ch", last_ch, 4'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
